// File: rtl/mac_array.sv
// mac_array: LANES parallel multiply-accumulate lanes sharing one coefficient
// stream. Each result group is a TAPS-long dot product; GROUPS groups make a
// frame. Results leave over a valid/ready handshake with back-pressure.
// Optional build macro: MAC_SIGNED_COEF_EN (two's complement coefficients,
// signed accumulators). Undefined: coefficients and results are unsigned.
module mac_array #(
  parameter int LANES  = 4,
  parameter int DW     = 8,
  parameter int CW     = 7,
  parameter int TAPS   = 8,
  parameter int GROUPS = 8,
  localparam int TW    = $clog2(TAPS),
  localparam int ACCW  = DW + CW + TW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LANES*DW-1:0]   x_data,
  input  logic [CW-1:0]         coef,
  output logic [TW-1:0]         coef_addr,
  output logic                  x_shift,
  output logic [LANES*ACCW-1:0] mu,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
  localparam logic [GW-1:0] GROUP_LAST = GW'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   tap;
  logic [GW-1:0]   group;
  logic [ACCW-1:0] acc  [LANES];
  logic [ACCW-1:0] prod [LANES];
  logic [ACCW-1:0] c_ext;
  logic [ACCW-1:0] x_ext;

  // State register; reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = MAC;
      MAC:  if (tap == TAP_LAST) state_next = OUT;
      OUT:  if (out_valid && out_ready)
              state_next = (group == GROUP_LAST) ? DONE : MAC;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Unregistered outputs decoded from registered state and tap counter.
  always_comb begin
    coef_addr = tap;
    x_shift   = (state == MAC);
  end

  // Per-lane products; low ACCW bits are correct for both number formats.
  always_comb begin
`ifdef MAC_SIGNED_COEF_EN
    c_ext = {{(ACCW-CW){coef[CW-1]}}, coef};
`else
    c_ext = {{(ACCW-CW){1'b0}}, coef};
`endif
    x_ext = '0;
    for (int l = 0; l < LANES; l++) begin
      x_ext   = {{(ACCW-DW){1'b0}}, x_data[l*DW +: DW]};
      prod[l] = x_ext * c_ext;
    end
  end

  // Counters, accumulators and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap        <= '0;
      group      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      busy       <= (state_next != IDLE);
      frame_done <= (state_next == DONE);
      if (abort) begin
        tap       <= '0;
        group     <= '0;
        out_valid <= 1'b0;
        for (int l = 0; l < LANES; l++) acc[l] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              tap   <= '0;
              group <= '0;
            end
          end
          MAC: begin
            for (int l = 0; l < LANES; l++)
              acc[l] <= (tap == '0) ? prod[l] : acc[l] + prod[l];
            if (tap == TAP_LAST) out_valid <= 1'b1;
            else                 tap       <= tap + TW'(1);
          end
          OUT: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              tap       <= '0;
              group     <= (group == GROUP_LAST) ? '0 : group + GW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Flatten the lane accumulators onto the result bus.
  for (genvar g = 0; g < LANES; g++) begin : g_mu
    assign mu[g*ACCW +: ACCW] = acc[g];
  end

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: directed self-checking bench for mac_array at default sizes.
// Coefficient ROM is modelled as a combinational table indexed by coef_addr.
module tb_mac_array;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int CW    = 7;
  localparam int TAPS  = 8;
  localparam int TW    = 3;
  localparam int ACCW  = 18;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic                  abort;
  logic [LANES*DW-1:0]   x_data;
  logic [CW-1:0]         coef;
  logic [TW-1:0]         coef_addr;
  logic                  x_shift;
  logic [LANES*ACCW-1:0] mu;
  logic                  out_valid;
  logic                  out_ready;
  logic                  frame_done;
  logic                  busy;

  logic [CW-1:0] rom [TAPS];
  int tests;
  int failed;
  logic [ACCW-1:0] mu_hold [LANES];

  mac_array dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .x_data     (x_data),
    .coef       (coef),
    .coef_addr  (coef_addr),
    .x_shift    (x_shift),
    .mu         (mu),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational coefficient ROM.
  always_comb coef = rom[coef_addr];

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start     = s;
    abort     = a;
    out_ready = r;
  endtask

  task automatic setRom(input logic [CW-1:0] v);
    for (int t = 0; t < TAPS; t++) rom[t] = v;
  endtask

  task automatic setLanes(input logic [DW-1:0] base, input logic inc);
    for (int l = 0; l < LANES; l++)
      x_data[l*DW +: DW] = inc ? DW'(l + 1) : base;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkLanes(input string tag, input logic [ACCW-1:0] e0,
                            input logic [ACCW-1:0] step);
    for (int l = 0; l < LANES; l++)
      checkOutput($sformatf("%s_lane%0d", tag, l), 64'(mu[l*ACCW +: ACCW]),
                  64'(e0 + ACCW'(l) * step));
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_mu"}, 64'(mu), 64'd0);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(frame_done), 64'd0);
    checkOutput({tag, "_shift"}, 64'(x_shift), 64'd0);
    checkOutput({tag, "_addr"}, 64'(coef_addr), 64'd0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    setRom(7'd1);
    setLanes(8'd1, 1'b0);

    // Reset state
    #2 rst = 1'b0;
    #1;
    checkIdleZero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    checkIdleZero("post_reset");

    // Frame A group 0: coef=1, x=1, out_ready low to exercise back-pressure
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int t = 0; t < TAPS; t++) begin
      checkOutput($sformatf("mac_addr_t%0d", t), 64'(coef_addr), 64'(t));
      checkOutput($sformatf("mac_shift_t%0d", t), 64'(x_shift), 64'd1);
      checkOutput($sformatf("mac_valid_t%0d", t), 64'(out_valid), 64'd0);
      tick();
    end
    checkOutput("ones_valid", 64'(out_valid), 64'd1);
    checkOutput("ones_busy", 64'(busy), 64'd1);
    checkLanes("ones_mu", 18'd8, 18'd0);

    // Change inputs during OUT: results must not move
    setRom(7'd127);
    setLanes(8'd255, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp_valid_c%0d", c), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp_shift_c%0d", c), 64'(x_shift), 64'd0);
      checkOutput($sformatf("bp_addr_c%0d", c), 64'(coef_addr), 64'd7);
      checkLanes($sformatf("bp_mu_c%0d", c), 18'd8, 18'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("bp_valid_c5", 64'(out_valid), 64'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resume_addr", 64'(coef_addr), 64'd0);
    checkOutput("resume_shift", 64'(x_shift), 64'd1);
    checkOutput("resume_valid", 64'(out_valid), 64'd0);
    for (int t = 0; t < TAPS; t++) tick();
    checkOutput("max_valid", 64'(out_valid), 64'd1);
    checkLanes("max_mu", 18'd259080, 18'd0);

    // Group 2 started, abort at tap 3
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("pre_abort_addr", 64'(coef_addr), 64'd3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkIdleZero("abort");
    tick();
    checkOutput("abort_done_later", 64'(frame_done), 64'd0);
    checkOutput("abort_busy_later", 64'(busy), 64'd0);

    // Fresh frame after abort: coef=t+1, lane l x=l+1 -> 36*(l+1)
    for (int t = 0; t < TAPS; t++) rom[t] = CW'(t + 1);
    setLanes(8'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int t = 0; t < TAPS; t++) tick();
    checkOutput("fresh_valid", 64'(out_valid), 64'd1);
    checkLanes("fresh_mu", 18'd36, 18'd36);

    // Async reset mid-MAC of group 1
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    checkIdleZero("async_rst");
    #1 rst = 1'b1;
    tick();
    checkIdleZero("after_rst");

    // Full frame: coef=2, lane l x=l+1, out_ready held high, stray start
    setRom(7'd2);
    setLanes(8'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int idx = 0; idx < 80; idx++) begin
      automatic logic exp_valid;
      exp_valid = (idx >= 8) && (idx <= 71) && (((idx - 8) % 9) == 0);
      checkOutput($sformatf("frame_valid_i%0d", idx), 64'(out_valid),
                  64'(exp_valid));
      checkOutput($sformatf("frame_done_i%0d", idx), 64'(frame_done),
                  64'(idx == 72));
      checkOutput($sformatf("frame_busy_i%0d", idx), 64'(busy),
                  64'(idx <= 72));
      if (exp_valid) checkLanes($sformatf("frame_mu_i%0d", idx), 18'd16, 18'd16);
      applyStimulus((idx == 20), 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Coefficient 7'h7F with x=10: -1 signed, 127 unsigned
    setRom(7'h7F);
    setLanes(8'd10, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int t = 0; t < TAPS; t++) tick();
    checkOutput("coef7f_valid", 64'(out_valid), 64'd1);
`ifdef MAC_SIGNED_COEF_EN
    checkLanes("coef7f_mu", 18'h3FFB0, 18'd0);
`else
    checkLanes("coef7f_mu", 18'd10160, 18'd0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkIdleZero("final_abort");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
